// File: rtl/aes_bus_master.sv
// Bus initiator that turns one 128-bit AES job into single-cycle register accesses on the responder bus.
// Optional job statistics counters: define AES_BUS_MASTER_STATS_EN.
module aes_bus_master #(
    parameter logic [7:0] ADDR_KEY      = 8'h10,
    parameter logic [7:0] ADDR_BLOCK    = 8'h20,
    parameter logic [7:0] ADDR_RESULT   = 8'h30,
    parameter logic [7:0] ADDR_CTRL     = 8'h08,
    parameter logic [7:0] ADDR_STATUS   = 8'h09,
    parameter logic [7:0] ADDR_CONFIG   = 8'h0a,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         POLL_LIMIT    = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_block,
    input  logic [127:0] req_key,
    input  logic         req_key_load,
    input  logic         req_encdec,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_timeout,
    output logic         busy,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [127:0] write_data,
    input  logic [127:0] read_data,
    output logic [15:0]  op_count,
    output logic [7:0]   timeout_count
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR_CFG    = 4'd1;
    localparam logic [3:0] WR_KEY    = 4'd2;
    localparam logic [3:0] WR_INIT   = 4'd3;
    localparam logic [3:0] WAIT_INIT = 4'd4;
    localparam logic [3:0] WR_BLOCK  = 4'd5;
    localparam logic [3:0] WR_NEXT   = 4'd6;
    localparam logic [3:0] WAIT_RES  = 4'd7;
    localparam logic [3:0] RD_RES    = 4'd8;
    localparam logic [3:0] RESP      = 4'd9;

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    logic [3:0]   state, state_n;
    logic [127:0] job_block, job_key;
    logic         job_key_load, job_encdec;
    logic [PW-1:0] poll_cnt, poll_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic         cs_n, we_n;
    logic [7:0]   addr_n;
    logic [127:0] wdata_n;
    logic         req_ready_n, rsp_valid_n, rsp_to_n;
    logic [127:0] rsp_data_n;
    logic         accept, settle_done, poll_last, status_ok;

    assign accept      = (state == IDLE) && req_valid && req_ready;
    assign settle_done = int'(settle_cnt) >= SETTLE_CYCLES - 1;
    assign poll_last   = poll_cnt == PW'(POLL_LIMIT - 1);
    assign status_ok   = (state == WAIT_INIT) ? read_data[0] : (read_data[1:0] == 2'b11);
    assign busy        = state != IDLE;

    // Every access state uses the registered cs as its phase: issue when cs=0, retire when cs=1.
    always_comb begin
        state_n     = state;
        cs_n        = 1'b0;
        we_n        = 1'b0;
        addr_n      = 8'h00;
        wdata_n     = '0;
        poll_n      = poll_cnt;
        settle_n    = settle_cnt;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_to_n    = rsp_timeout;
        rsp_data_n  = rsp_data;
        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (accept) begin
                    req_ready_n = 1'b0;
                    state_n     = WR_CFG;
                end
            end
            WR_CFG: begin
                if (!cs) begin
                    cs_n = 1'b1; we_n = 1'b1; addr_n = ADDR_CONFIG;
                    wdata_n = {127'b0, job_encdec};
                end else begin
                    state_n = job_key_load ? WR_KEY : WR_BLOCK;
                end
            end
            WR_KEY: begin
                if (!cs) begin
                    cs_n = 1'b1; we_n = 1'b1; addr_n = ADDR_KEY; wdata_n = job_key;
                end else begin
                    state_n = WR_INIT;
                end
            end
            WR_INIT, WR_NEXT: begin
                if (!cs) begin
                    cs_n = 1'b1; we_n = 1'b1; addr_n = ADDR_CTRL;
                    wdata_n = (state == WR_INIT) ? 128'h1 : 128'h2;
                end else begin
                    state_n  = (state == WR_INIT) ? WAIT_INIT : WAIT_RES;
                    settle_n = '0;
                    poll_n   = '0;
                end
            end
            WAIT_INIT, WAIT_RES: begin
                if (!cs) begin
                    // settle_cnt stays saturated after a failed poll, so retries come after one gap cycle
                    if (settle_done) begin
                        cs_n = 1'b1; addr_n = ADDR_STATUS;
                    end else begin
                        settle_n = settle_cnt + SW'(1);
                    end
                end else begin
                    poll_n = poll_cnt + PW'(1);
                    if (status_ok) begin
                        state_n = (state == WAIT_INIT) ? WR_BLOCK : RD_RES;
                    end else if (poll_last) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_to_n    = 1'b1;
                        rsp_data_n  = '0;
                    end
                end
            end
            WR_BLOCK: begin
                if (!cs) begin
                    cs_n = 1'b1; we_n = 1'b1; addr_n = ADDR_BLOCK; wdata_n = job_block;
                end else begin
                    state_n = WR_NEXT;
                end
            end
            RD_RES: begin
                if (!cs) begin
                    cs_n = 1'b1; addr_n = ADDR_RESULT;
                end else begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = read_data;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    rsp_to_n    = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cs           <= 1'b0;
            we           <= 1'b0;
            address      <= 8'h00;
            write_data   <= '0;
            poll_cnt     <= '0;
            settle_cnt   <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_data     <= '0;
            job_block    <= '0;
            job_key      <= '0;
            job_key_load <= 1'b0;
            job_encdec   <= 1'b0;
        end else begin
            state       <= state_n;
            cs          <= cs_n;
            we          <= we_n;
            address     <= addr_n;
            write_data  <= wdata_n;
            poll_cnt    <= poll_n;
            settle_cnt  <= settle_n;
            req_ready   <= req_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_timeout <= rsp_to_n;
            rsp_data    <= rsp_data_n;
            if (accept) begin
                job_block    <= req_block;
                job_key      <= req_key;
                job_key_load <= req_key_load;
                job_encdec   <= req_encdec;
            end
        end
    end

`ifdef AES_BUS_MASTER_STATS_EN
    logic        rsp_hs;
    logic [15:0] op_cnt_q;
    logic [7:0]  to_cnt_q;

    assign rsp_hs = (state == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
            to_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (rsp_timeout) to_cnt_q <= to_cnt_q + 8'd1;
            else             op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count      = op_cnt_q;
    assign timeout_count = to_cnt_q;
`else
    assign op_count      = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master: a behavioural AES responder on the bus, an expected-access
// queue built per job from its fields, and a per-cycle compare process on the bus/response outputs.
`timescale 1ns/1ps
module tb_aes_bus_master;

    localparam logic [7:0] A_KEY = 8'h10, A_BLOCK = 8'h20, A_RESULT = 8'h30;
    localparam logic [7:0] A_CTRL = 8'h08, A_STATUS = 8'h09, A_CONFIG = 8'h0a;
    localparam int SETTLE = 2;
    localparam int PLIM   = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, rst_n;
    logic         req_valid, req_ready, req_key_load, req_encdec;
    logic [127:0] req_block, req_key;
    logic         rsp_valid, rsp_ready, rsp_timeout, busy, cs, we;
    logic [127:0] rsp_data, write_data, read_data;
    logic [7:0]   address, timeout_count;
    logic [15:0]  op_count;

    aes_bus_master #(.SETTLE_CYCLES(SETTLE), .POLL_LIMIT(PLIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block), .req_key(req_key),
        .req_key_load(req_key_load), .req_encdec(req_encdec),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data),
        .op_count(op_count), .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Stand-in cipher: known FIPS-197 pair, otherwise a simple reversible mix.
    function automatic logic [127:0] aes_fn(input logic [127:0] k, input logic [127:0] b, input logic e);
        if (k == FIPS_KEY && e && b == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && !e && b == FIPS_CT) return FIPS_PT;
        return b ^ k ^ {128{e}};
    endfunction

    // Responder: init takes 3 cycles, next takes 5; 'stuck' forces STATUS to 0.
    logic [127:0] r_key, r_block, r_result;
    logic         r_enc, r_done, stuck;
    int           r_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0; r_block <= '0; r_result <= '0;
            r_enc <= 1'b0; r_done <= 1'b0; r_busy <= 0;
        end else begin
            if (r_busy > 0) r_busy <= r_busy - 1;
            if (cs && we) begin
                case (address)
                    A_KEY:    r_key <= write_data;
                    A_BLOCK:  r_block <= write_data;
                    A_CONFIG: r_enc <= write_data[0];
                    A_CTRL: begin
                        if (write_data[0]) begin
                            r_busy <= 3; r_done <= 1'b0;
                        end else if (write_data[1]) begin
                            r_busy <= 5; r_done <= 1'b1;
                            r_result <= aes_fn(r_key, r_block, r_enc);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (address == A_STATUS)
            read_data = stuck ? '0 : {126'b0, r_done && (r_busy == 0), r_busy == 0};
        else if (address == A_RESULT)
            read_data = r_result;
    end

    typedef struct {
        logic [7:0]   addr;
        logic         we;
        logic [127:0] data;
    } acc_t;

    acc_t         exp_q[$];
    int           poll_cnt, idle_cnt, edges;
    logic [7:0]   last_np;
    logic         prev_cs, prev_rv, prev_rr, first_poll, next_seen;
    logic [127:0] prev_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Per-cycle compare against the expected access queue and the protocol rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_rd = '0;
            idle_cnt = 10; last_np = 8'h00; first_poll = 1'b0;
        end else begin
            chk("wdata_zero_when_not_writing", (cs && we) ? 128'h0 : write_data, 128'h0);
            if (edges > 0) chk("req_ready_vs_busy", req_ready, !busy);
            if (prev_rv && !prev_rr) begin
                chk("rsp_hold_valid", rsp_valid, 1'b1);
                chk("rsp_hold_data", rsp_data, prev_rd);
            end
            if (rsp_valid) chk("bus_idle_in_resp", cs, 1'b0);
            if (cs) begin
                chk("cs_gap", prev_cs, 1'b0);
                if (address == A_STATUS && !we) begin
                    chk("poll_after_ctrl", last_np, A_CTRL);
                    if (first_poll) chk("settle_gap", idle_cnt >= SETTLE, 1'b1);
                    first_poll = 1'b0;
                    poll_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access: addr %h we %b data %h", address, we, write_data);
                    end else begin
                        acc_t e;
                        e = exp_q.pop_front();
                        chk("access_addr", address, e.addr);
                        chk("access_we", we, e.we);
                        chk("access_data", write_data, e.data);
                    end
                    last_np = address;
                    if (address == A_CTRL) first_poll = 1'b1;
                    if (address == A_CTRL && write_data == 128'h2) next_seen = 1'b1;
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            prev_cs = cs; prev_rv = rsp_valid; prev_rr = rsp_ready; prev_rd = rsp_data;
        end
    end

    logic [127:0] model_key, exp_data, got_data;
    logic         exp_to;
    int           exp_ops, exp_tos;

    task automatic send_job(input logic [127:0] key, input logic [127:0] block, input logic kl, input logic enc);
        int n;
        exp_q.push_back(acc_t'{A_CONFIG, 1'b1, {127'b0, enc}});
        if (kl) begin
            exp_q.push_back(acc_t'{A_KEY, 1'b1, key});
            exp_q.push_back(acc_t'{A_CTRL, 1'b1, 128'h1});
            model_key = key;
        end
        exp_q.push_back(acc_t'{A_BLOCK, 1'b1, block});
        exp_q.push_back(acc_t'{A_CTRL, 1'b1, 128'h2});
        if (stuck) begin
            exp_data = '0; exp_to = 1'b1;
        end else begin
            exp_q.push_back(acc_t'{A_RESULT, 1'b0, 128'h0});
            exp_data = aes_fn(model_key, block, enc); exp_to = 1'b0;
        end
        poll_cnt = 0; next_seen = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1; req_key = key; req_block = block; req_key_load = kl; req_encdec = enc;
        @(posedge clk); #1;
        req_valid = 1'b0; req_key = '0; req_block = '0; req_key_load = 1'b0; req_encdec = 1'b0;
    endtask

    task automatic finish_job(input int hold);
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
        chk("rsp_valid_wait", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_timeout", rsp_timeout, exp_to);
        got_data = rsp_data;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_req_ready_low", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("req_ready_after_hs", req_ready, 1'b1);
        chk("rsp_timeout_clear", rsp_timeout, 1'b0);
        if (exp_to) exp_tos++; else exp_ops++;
        chk("accesses_drained", exp_q.size(), 0);
`ifdef AES_BUS_MASTER_STATS_EN
        chk("op_count", op_count, exp_ops);
        chk("timeout_count", timeout_count, exp_tos);
`else
        chk("op_count_tied", op_count, 0);
        chk("timeout_count_tied", timeout_count, 0);
`endif
    endtask

    initial begin
        int n;
        rst_n = 1'b0; stuck = 1'b0;
        req_valid = 1'b0; req_key = '0; req_block = '0; req_key_load = 1'b0; req_encdec = 1'b0;
        rsp_ready = 1'b0; model_key = '0; exp_ops = 0; exp_tos = 0;
        poll_cnt = 0; next_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cs", cs, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_address", address, 8'h00);
        chk("rst_write_data", write_data, 128'h0);
        chk("rst_op_count", op_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready_after_reset", req_ready, 1'b1);

        // FIPS-197 encrypt with key load
        send_job(FIPS_KEY, FIPS_PT, 1'b1, 1'b1);
        finish_job(0);
        chk("lit_fips_encrypt", got_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // decrypt reusing the loaded key, response held 20 cycles
        send_job(128'h0, FIPS_CT, 1'b0, 1'b0);
        finish_job(20);
        chk("lit_fips_decrypt", got_data, 128'h00112233445566778899aabbccddeeff);

        // responder never ready: exactly PLIM status reads then timeout
        stuck = 1'b1;
        send_job(128'h0, 128'h1234, 1'b0, 1'b1);
        finish_job(3);
        chk("timeout_poll_count", poll_cnt, PLIM);
        chk("lit_timeout_data", got_data, 128'h0);
        stuck = 1'b0;

        // key reuse with a non-FIPS block: zero block, decrypt returns the key
        send_job(128'h0, 128'h0, 1'b0, 1'b0);
        finish_job(1);
        chk("lit_key_passthrough", got_data, 128'h000102030405060708090a0b0c0d0e0f);

        // reset while waiting for the result
        send_job(FIPS_KEY, FIPS_PT, 1'b1, 1'b1);
        n = 0;
        while (!next_seen && n < 100) begin @(posedge clk); #1; n++; end
        chk("next_written_before_reset", next_seen, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_cs", cs, 1'b0);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        exp_q.delete(); model_key = '0; exp_ops = 0; exp_tos = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_req_ready", req_ready, 1'b1);

        // three good jobs after reset
        send_job(FIPS_KEY, FIPS_PT, 1'b1, 1'b1);
        finish_job(0);
        chk("lit_fresh_encrypt", got_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        send_job(128'h0, 128'h1, 1'b0, 1'b1);
        finish_job(2);
        chk("lit_mix_encrypt", got_data, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f1);
        send_job(128'h0, FIPS_CT, 1'b0, 1'b0);
        finish_job(0);
`ifdef AES_BUS_MASTER_STATS_EN
        chk("lit_op_count_3", op_count, 16'd3);
`else
        chk("lit_op_count_off", op_count, 16'd0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
